// File: rtl/nic_bus_arbiter.sv
// Round-robin arbiter that sequences N_REQ requesters onto the single
// two-phase master port of nic_top (setup, access, capture, then respond).
module nic_bus_arbiter #(
    parameter int N_REQ  = 4,
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_REQ-1:0]         req,
    input  logic [N_REQ-1:0]         req_wr,
    input  logic [N_REQ*ADDR_W-1:0]  req_addr,
    input  logic [N_REQ*DATA_W-1:0]  req_wdata,
    output logic [N_REQ-1:0]         rsp_done,
    output logic [DATA_W-1:0]        rsp_rdata,
    output logic [$clog2(N_REQ)-1:0] grant_id,
    output logic                     busy,
    output logic                     master_sel,
    output logic                     master_enable,
    output logic                     master_wr_dir,
    output logic [ADDR_W-1:0]        master_addr,
    output logic [DATA_W-1:0]        master_wdata,
    input  logic [DATA_W-1:0]        master_rdata
);

    localparam int GW = $clog2(N_REQ);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, CAPTURE} state_t;

    state_t            state, state_nxt;
    logic [GW-1:0]     last_grant;
    logic [GW-1:0]     winner;
    logic              win_valid;
    logic [N_REQ-1:0]  eligible;
    logic              lat_wr;
    logic [ADDR_W-1:0] lat_addr;
    logic [DATA_W-1:0] lat_wdata;
    logic [ADDR_W-1:0] addr_arr  [N_REQ];
    logic [DATA_W-1:0] wdata_arr [N_REQ];

    for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
        assign addr_arr[g]  = req_addr[g*ADDR_W +: ADDR_W];
        assign wdata_arr[g] = req_wdata[g*DATA_W +: DATA_W];
    end

    // A requester whose done pulse is showing is masked so one request is served once.
    assign eligible = req & ~rsp_done;

    always_comb begin
        int sum;
        // NOTE: every comb output gets a default first; a missed path would infer a latch.
        sum       = 0;
        win_valid = 1'b0;
        winner    = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            sum = int'(last_grant) + k;
            if (sum >= N_REQ) sum = sum - N_REQ;
            if (!win_valid && eligible[GW'(sum)]) begin
                win_valid = 1'b1;
                winner    = GW'(sum);
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update as one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (win_valid) state_nxt = SETUP;
            SETUP:   state_nxt = ACCESS;
            ACCESS:  state_nxt = CAPTURE;
            CAPTURE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Strobes decode only the state register, never the req inputs.
    always_comb begin
        busy          = 1'b1;
        master_sel    = 1'b0;
        master_enable = 1'b0;
        case (state)
            IDLE:    busy = 1'b0;
            SETUP:   master_sel = 1'b1;
            ACCESS: begin
                master_sel    = 1'b1;
                master_enable = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: latched command registers are reset too, so master_* read 0 after reset.
            last_grant <= GW'(N_REQ - 1);
            grant_id   <= '0;
            lat_wr     <= 1'b0;
            lat_addr   <= '0;
            lat_wdata  <= '0;
        end else if (state == IDLE && win_valid) begin
            last_grant <= winner;
            grant_id   <= winner;
            lat_wr     <= req_wr[winner];
            lat_addr   <= addr_arr[winner];
            lat_wdata  <= wdata_arr[winner];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_done  <= '0;
            rsp_rdata <= '0;
        end else begin
            rsp_done <= '0;
            if (state == CAPTURE) begin
                rsp_done[grant_id] <= 1'b1;
                rsp_rdata          <= master_rdata;
            end
        end
    end

    assign master_wr_dir = lat_wr;
    assign master_addr   = lat_addr;
    assign master_wdata  = lat_wdata;

endmodule

// File: tb/tb_nic_bus_arbiter.sv
// Bench for nic_bus_arbiter: directed scenarios plus randomized requesters
// checked against a transaction-level reference model.
module tb_nic_bus_arbiter;

    localparam int N  = 4;
    localparam int AW = 16;
    localparam int DW = 16;
    localparam int GW = 2;

    logic            clk;
    logic            rst;
    logic [N-1:0]    req;
    logic [N-1:0]    req_wr;
    logic [N*AW-1:0] req_addr;
    logic [N*DW-1:0] req_wdata;
    logic [N-1:0]    rsp_done;
    logic [DW-1:0]   rsp_rdata;
    logic [GW-1:0]   grant_id;
    logic            busy;
    logic            master_sel;
    logic            master_enable;
    logic            master_wr_dir;
    logic [AW-1:0]   master_addr;
    logic [DW-1:0]   master_wdata;
    logic [DW-1:0]   master_rdata;

    int n_cmp = 0;
    int n_bad = 0;

    int            d_order[$];
    int            d_cycle[$];
    logic [DW-1:0] d_data[$];

    nic_bus_arbiter #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .rst(rst), .req(req), .req_wr(req_wr), .req_addr(req_addr),
        .req_wdata(req_wdata), .rsp_done(rsp_done), .rsp_rdata(rsp_rdata),
        .grant_id(grant_id), .busy(busy), .master_sel(master_sel),
        .master_enable(master_enable), .master_wr_dir(master_wr_dir),
        .master_addr(master_addr), .master_wdata(master_wdata),
        .master_rdata(master_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Simple nic_top stand-in: write on the access edge, read combinationally.
    logic [DW-1:0] mem [256];
    initial for (int j = 0; j < 256; j++) mem[j] = '0;
    always @(posedge clk)
        if (master_sel && master_enable && master_wr_dir) mem[master_addr[7:0]] <= master_wdata;
    assign master_rdata = mem[master_addr[7:0]];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cmd(input int i, input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
        req[i]               = 1'b1;
        req_wr[i]            = wr;
        req_addr[i*AW +: AW] = a;
        req_wdata[i*DW +: DW] = d;
    endtask

    task automatic do_reset();
        req = '0;
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    // Runs until every request is served; each requester drops req the cycle after its done.
    task automatic serve_all(input string name, input int budget);
        logic [N-1:0] drop;
        int cyc;
        drop = '0;
        cyc  = 0;
        d_order.delete();
        d_cycle.delete();
        d_data.delete();
        while (req != '0 && cyc < budget) begin
            step();
            cyc++;
            for (int i = 0; i < N; i++)
                if (drop[i]) begin
                    req[i]  = 1'b0;
                    drop[i] = 1'b0;
                end
            for (int i = 0; i < N; i++)
                if (rsp_done[i]) begin
                    d_order.push_back(i);
                    d_cycle.push_back(cyc);
                    d_data.push_back(rsp_rdata);
                    drop[i] = 1'b1;
                end
        end
        n_cmp++;
        if (req != '0) begin
            n_bad++;
            $display("FAIL %s_timeout: req still %b after %0d cycles, required all served", name, req, budget);
        end
    endtask

    task automatic test_reset();
        req = '0; req_wr = '0; req_addr = '0; req_wdata = '0;
        #1 rst = 1'b1;
        #1;
        n_cmp++; if ({busy, master_sel, master_enable, master_wr_dir} !== 4'b0000) begin
            n_bad++; $display("FAIL reset_ctrl: got %b required 0000", {busy, master_sel, master_enable, master_wr_dir}); end
        n_cmp++; if (rsp_done !== '0) begin n_bad++; $display("FAIL reset_done: got %b required 0", rsp_done); end
        n_cmp++; if (rsp_rdata !== '0) begin n_bad++; $display("FAIL reset_rdata: got %h required 0", rsp_rdata); end
        n_cmp++; if (grant_id !== '0) begin n_bad++; $display("FAIL reset_grant: got %0d required 0", grant_id); end
        n_cmp++; if ({master_addr, master_wdata} !== '0) begin
            n_bad++; $display("FAIL reset_bus: addr %h wdata %h required 0", master_addr, master_wdata); end
        step();
        rst = 1'b0;
        step();
        n_cmp++; if (busy !== 1'b0 || rsp_done !== '0) begin
            n_bad++; $display("FAIL reset_idle: busy %b done %b required 0/0", busy, rsp_done); end
    endtask

    task automatic test_write_read();
        do_reset();
        set_cmd(0, 1'b1, 16'h0002, 16'hABCD);
        step();
        n_cmp++; if ({master_sel, master_enable, master_wr_dir, busy} !== 4'b1011) begin
            n_bad++; $display("FAIL wr_setup: sel/en/wr/busy %b required 1011", {master_sel, master_enable, master_wr_dir, busy}); end
        n_cmp++; if (master_addr !== 16'h0002 || master_wdata !== 16'hABCD) begin
            n_bad++; $display("FAIL wr_setup_bus: addr %h wdata %h required 0002/abcd", master_addr, master_wdata); end
        step();
        n_cmp++; if ({master_sel, master_enable, master_wr_dir, busy} !== 4'b1111) begin
            n_bad++; $display("FAIL wr_access: sel/en/wr/busy %b required 1111", {master_sel, master_enable, master_wr_dir, busy}); end
        step();
        n_cmp++; if ({master_sel, master_enable, master_wr_dir, busy} !== 4'b0011 || master_addr !== 16'h0002) begin
            n_bad++; $display("FAIL wr_capture: sel/en/wr/busy %b addr %h required 0011/0002",
                              {master_sel, master_enable, master_wr_dir, busy}, master_addr); end
        step();
        n_cmp++; if (rsp_done !== 4'b0001 || busy !== 1'b0) begin
            n_bad++; $display("FAIL wr_done: done %b busy %b required 0001/0", rsp_done, busy); end
        step();
        n_cmp++; if (rsp_done !== 4'b0000 || busy !== 1'b0) begin
            n_bad++; $display("FAIL wr_done_width: done %b busy %b required 0000/0", rsp_done, busy); end
        set_cmd(0, 1'b0, 16'h0002, 16'h0000);
        repeat (3) step();
        n_cmp++; if (rsp_done !== 4'b0000) begin n_bad++; $display("FAIL rd_early: done %b required 0000", rsp_done); end
        step();
        n_cmp++; if (rsp_done !== 4'b0001 || rsp_rdata !== 16'hABCD) begin
            n_bad++; $display("FAIL rd_done: done %b rdata %h required 0001/abcd", rsp_done, rsp_rdata); end
        step();
        req[0] = 1'b0;
        step();
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rd_no_repeat: busy %b required 0", busy); end
    endtask

    task automatic test_all_four();
        do_reset();
        for (int i = 0; i < N; i++) set_cmd(i, 1'b1, 16'(16'h0010 + i), 16'(16'hA000 + i * 16'h0101));
        serve_all("all4_wr", 40);
        n_cmp++; if (d_order.size() != N) begin n_bad++; $display("FAIL all4_wr_count: got %0d required %0d", d_order.size(), N); end
        for (int k = 0; k < d_order.size() && k < N; k++) begin
            n_cmp++; if (d_order[k] != k || d_cycle[k] != 4 + 4 * k) begin
                n_bad++; $display("FAIL all4_wr_order[%0d]: id %0d cycle %0d required %0d/%0d", k, d_order[k], d_cycle[k], k, 4 + 4 * k); end
        end
        for (int i = 0; i < N; i++) set_cmd(i, 1'b0, 16'(16'h0010 + i), 16'h0000);
        serve_all("all4_rd", 40);
        n_cmp++; if (d_order.size() != N) begin n_bad++; $display("FAIL all4_rd_count: got %0d required %0d", d_order.size(), N); end
        for (int k = 0; k < d_order.size() && k < N; k++) begin
            n_cmp++; if (d_order[k] != k || d_data[k] !== 16'(16'hA000 + k * 16'h0101)) begin
                n_bad++; $display("FAIL all4_rd[%0d]: id %0d data %h required %0d/%h", k, d_order[k], d_data[k], k, 16'(16'hA000 + k * 16'h0101)); end
        end
    endtask

    task automatic test_alternate();
        int ids[$];
        int cyc, last_cyc, n1, n3;
        do_reset();
        set_cmd(1, 1'b1, 16'h0060, 16'h0101);
        set_cmd(3, 1'b0, 16'h0060, 16'h0000);
        cyc = 0;
        last_cyc = 0;
        while (ids.size() < 20 && cyc < 120) begin
            step();
            cyc++;
            for (int i = 0; i < N; i++)
                if (rsp_done[i]) begin
                    ids.push_back(i);
                    last_cyc = cyc;
                end
        end
        n_cmp++; if (ids.size() != 20 || last_cyc != 80) begin
            n_bad++; $display("FAIL alt_count: %0d dones by cycle %0d required 20 by 80", ids.size(), last_cyc); end
        n1 = 0;
        n3 = 0;
        for (int k = 0; k < ids.size(); k++) begin
            n_cmp++; if (ids[k] != ((k % 2 == 0) ? 1 : 3)) begin
                n_bad++; $display("FAIL alt_order[%0d]: id %0d required %0d", k, ids[k], (k % 2 == 0) ? 1 : 3); end
            if (ids[k] == 1) n1++;
            if (ids[k] == 3) n3++;
        end
        n_cmp++; if (n1 != 10 || n3 != 10) begin n_bad++; $display("FAIL alt_starve: got %0d/%0d required 10/10", n1, n3); end
        step();
        req = '0;
        repeat (6) step();
    endtask

    task automatic test_single_hold();
        int nd, dc0, dc1;
        logic change;
        logic [DW-1:0] rd2;
        do_reset();
        set_cmd(2, 1'b1, 16'h0020, 16'h5A5A);
        nd = 0; dc0 = 0; dc1 = 0; change = 1'b0; rd2 = '0;
        for (int c = 1; c <= 24; c++) begin
            step();
            if (change) begin
                if (nd == 1) set_cmd(2, 1'b0, 16'h0020, 16'h0000);
                else req[2] = 1'b0;
                change = 1'b0;
            end
            if (rsp_done[2]) begin
                if (nd == 0) dc0 = c;
                if (nd == 1) begin dc1 = c; rd2 = rsp_rdata; end
                nd++;
                change = 1'b1;
            end
        end
        n_cmp++; if (nd != 2) begin n_bad++; $display("FAIL hold_count: got %0d done pulses required 2", nd); end
        n_cmp++; if (dc0 != 4 || dc1 - dc0 != 5) begin
            n_bad++; $display("FAIL hold_spacing: first %0d gap %0d required 4/5", dc0, dc1 - dc0); end
        n_cmp++; if (rd2 !== 16'h5A5A) begin n_bad++; $display("FAIL hold_rdata: got %h required 5a5a", rd2); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        set_cmd(0, 1'b1, 16'h0030, 16'h1111);
        step();
        step();
        #2 rst = 1'b1;
        #1;
        n_cmp++; if ({master_sel, master_enable, busy} !== 3'b000 || rsp_done !== '0) begin
            n_bad++; $display("FAIL mid_rst_async: sel/en/busy %b done %b required 000/0", {master_sel, master_enable, busy}, rsp_done); end
        n_cmp++; if (master_addr !== '0 || grant_id !== '0) begin
            n_bad++; $display("FAIL mid_rst_bus: addr %h grant %0d required 0/0", master_addr, grant_id); end
        req = '0;
        step();
        set_cmd(0, 1'b1, 16'h0031, 16'h2222);
        set_cmd(3, 1'b1, 16'h0033, 16'h4444);
        rst = 1'b0;
        serve_all("mid_rst", 30);
        n_cmp++; if (d_order.size() != 2) begin n_bad++; $display("FAIL mid_rst_count: got %0d required 2", d_order.size()); end
        else begin
            n_cmp++; if (d_order[0] != 0 || d_order[1] != 3 || d_cycle[0] != 4) begin
                n_bad++; $display("FAIL mid_rst_order: %0d,%0d first at %0d required 0,3 at 4", d_order[0], d_order[1], d_cycle[0]); end
        end
    endtask

    task automatic test_addr_change();
        do_reset();
        set_cmd(1, 1'b1, 16'h0040, 16'h3333);
        step();
        n_cmp++; if (master_addr !== 16'h0040) begin n_bad++; $display("FAIL latch_setup: addr %h required 0040", master_addr); end
        req_addr[1*AW +: AW]  = 16'h0077;
        req_wdata[1*DW +: DW] = 16'h7777;
        step();
        n_cmp++; if (master_addr !== 16'h0040 || master_wdata !== 16'h3333) begin
            n_bad++; $display("FAIL latch_access: addr %h wdata %h required 0040/3333", master_addr, master_wdata); end
        step();
        n_cmp++; if (master_addr !== 16'h0040) begin n_bad++; $display("FAIL latch_capture: addr %h required 0040", master_addr); end
        step();
        n_cmp++; if (rsp_done !== 4'b0010 || mem[8'h40] !== 16'h3333) begin
            n_bad++; $display("FAIL latch_done: done %b mem %h required 0010/3333", rsp_done, mem[8'h40]); end
        step();
        req[1] = 1'b0;
        step();
    endtask

    task automatic rand_cmd(input int i);
        set_cmd(i, 1'($urandom_range(0, 1)), 16'(16'h0050 + $urandom_range(0, 7)), 16'($urandom));
    endtask

    // Reference model: a grant made from the sampled inputs occupies the bus for
    // the next three cycles and completes with a done pulse one cycle later.
    task automatic test_random();
        logic [DW-1:0] ref_mem [256];
        logic [N-1:0]  seen_prev, elig, m_done, exp_done;
        logic [AW-1:0] m_addr;
        logic [DW-1:0] m_wdata, m_rdata, exp_rd;
        logic          m_wr, exp_rv, exp_busy;
        int m_since, m_last, m_grant, w, n_txn;
        do_reset();
        for (int j = 0; j < 256; j++) ref_mem[j] = mem[j];
        m_since = 0; m_last = N - 1; m_grant = 0; n_txn = 0;
        m_wr = 1'b0; m_addr = '0; m_wdata = '0; m_rdata = '0; m_done = '0; seen_prev = '0;
        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < N; i++) begin
                if (seen_prev[i]) begin
                    if ($urandom_range(0, 1) == 1) rand_cmd(i);
                    else req[i] = 1'b0;
                end else if (!req[i] && $urandom_range(0, 3) == 0) rand_cmd(i);
            end
            seen_prev = rsp_done;

            exp_done = '0;
            exp_rv   = 1'b0;
            exp_rd   = '0;
            if (m_since == 3) begin
                exp_done[m_grant] = 1'b1;
                exp_rv = !m_wr;
                exp_rd = m_rdata;
            end
            if (m_since == 0 || m_since >= 4) begin
                elig = req & ~m_done;
                w = -1;
                for (int k = 1; k <= N; k++)
                    if (w < 0 && elig[(m_last + k) % N]) w = (m_last + k) % N;
                if (w >= 0) begin
                    m_grant = w;
                    m_last  = w;
                    m_wr    = req_wr[w];
                    m_addr  = req_addr[w*AW +: AW];
                    m_wdata = req_wdata[w*DW +: DW];
                    if (m_wr) ref_mem[m_addr[7:0]] = m_wdata;
                    else m_rdata = ref_mem[m_addr[7:0]];
                    m_since = 1;
                end else m_since = 0;
            end else m_since++;
            m_done   = exp_done;
            exp_busy = (m_since >= 1 && m_since <= 3);
            if (exp_done != '0) n_txn++;

            step();
            n_cmp++; if (rsp_done !== m_done) begin n_bad++; $display("FAIL rnd_done c%0d: got %b required %b", c, rsp_done, m_done); end
            n_cmp++; if (busy !== exp_busy) begin n_bad++; $display("FAIL rnd_busy c%0d: got %b required %b", c, busy, exp_busy); end
            n_cmp++; if (grant_id !== GW'(m_grant)) begin n_bad++; $display("FAIL rnd_grant c%0d: got %0d required %0d", c, grant_id, m_grant); end
            n_cmp++; if (master_sel !== (m_since == 1 || m_since == 2) || master_enable !== (m_since == 2)) begin
                n_bad++; $display("FAIL rnd_strobe c%0d: sel %b en %b phase %0d", c, master_sel, master_enable, m_since); end
            if (exp_busy) begin
                n_cmp++; if (master_addr !== m_addr || master_wr_dir !== m_wr) begin
                    n_bad++; $display("FAIL rnd_cmd c%0d: addr %h wr %b required %h/%b", c, master_addr, master_wr_dir, m_addr, m_wr); end
                if (m_wr) begin
                    n_cmp++; if (master_wdata !== m_wdata) begin
                        n_bad++; $display("FAIL rnd_wdata c%0d: got %h required %h", c, master_wdata, m_wdata); end
                end
            end
            if (exp_rv) begin
                n_cmp++; if (rsp_rdata !== exp_rd) begin n_bad++; $display("FAIL rnd_rdata c%0d: got %h required %h", c, rsp_rdata, exp_rd); end
            end
        end
        n_cmp++; if (n_txn < 50) begin n_bad++; $display("FAIL rnd_activity: %0d transactions required at least 50", n_txn); end
        req = '0;
        repeat (8) step();
    endtask

    initial begin
        rst = 1'b0;
        test_reset();
        test_write_read();
        test_all_four();
        test_alternate();
        test_single_hold();
        test_reset_mid();
        test_addr_change();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
